// File: rtl/nn_arith_pkg.sv
// Shared arithmetic definitions for the neural-network datapath blocks
// (add/sub pipelines, accumulators, MAC units).
package nn_arith_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } addsub_mode_e;

    // One full-adder cell, returned as {carry_out, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Stream bundle of the pipelined adder/subtractor: operand beat in, result beat out,
// each with its own valid/ready pair.
interface pipelined_addsub_if
    import nn_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/addsub_stage.sv
// One carry segment of the pipelined adder: CHUNK-bit ripple of full-adder cells
// with a registered sum chunk and registered carry-out.
module addsub_stage
    import nn_arith_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK-1:0] s_comb;
    logic [CHUNK:0]   c;

    always_comb begin
        c      = '0;
        s_comb = '0;
        c[0]   = ci;
        for (int i = 0; i < CHUNK; i++) begin
            {c[i+1], s_comb[i]} = full_add(a[i], b[i], c[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else if (en) begin
            s  <= s_comb;
            co <= c[CHUNK];
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES registered ripple-carry segments with
// operand skew, result deskew and a valid/ready stream on both sides.
module pipelined_addsub
    import nn_arith_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_addsub_if.slave bus
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic              en;
    logic              is_sub;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] carry;
    logic [WIDTH-1:0]  sum_out;
    logic              a_msb_q;
    logic              b_msb_q;

    // The whole pipeline advances in lockstep; it only holds while the result is blocked.
    assign en           = !vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = en;
    assign is_sub       = (bus.sub == MODE_SUB);
    assign b_eff        = is_sub ? ~bus.b : bus.b;
    assign c0           = is_sub ? ~bus.cin : bus.cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (en) begin
            vld <= (vld << 1) | STAGES'(bus.in_valid);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] op_a;
        logic [CHUNK-1:0] op_b;
        logic             ci;
        logic [CHUNK-1:0] s_q;

        // Chunk k of the operands waits k cycles so it meets the carry from stage k-1.
        if (k == 0) begin : g_entry
            assign op_a = bus.a[CHUNK-1:0];
            assign op_b = b_eff[CHUNK-1:0];
            assign ci   = c0;
        end else begin : g_skew
            logic [CHUNK-1:0] a_d [k];
            logic [CHUNK-1:0] b_d [k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        a_d[j] <= '0;
                        b_d[j] <= '0;
                    end
                end else if (en) begin
                    a_d[0] <= bus.a[k*CHUNK +: CHUNK];
                    b_d[0] <= b_eff[k*CHUNK +: CHUNK];
                    for (int j = 1; j < k; j++) begin
                        a_d[j] <= a_d[j-1];
                        b_d[j] <= b_d[j-1];
                    end
                end
            end

            assign op_a = a_d[k-1];
            assign op_b = b_d[k-1];
            assign ci   = carry[k-1];
        end

        addsub_stage #(
            .CHUNK (CHUNK)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .a   (op_a),
            .b   (op_b),
            .ci  (ci),
            .s   (s_q),
            .co  (carry[k])
        );

        if (k == STAGES-1) begin : g_last
            assign sum_out[k*CHUNK +: CHUNK] = s_q;

            // Operand MSBs travel with the last stage so the carry into the MSB can be recovered.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_msb_q <= 1'b0;
                    b_msb_q <= 1'b0;
                end else if (en) begin
                    a_msb_q <= op_a[CHUNK-1];
                    b_msb_q <= op_b[CHUNK-1];
                end
            end
        end else begin : g_deskew
            localparam int D = STAGES - 1 - k;
            logic [CHUNK-1:0] s_d [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < D; j++) begin
                        s_d[j] <= '0;
                    end
                end else if (en) begin
                    s_d[0] <= s_q;
                    for (int j = 1; j < D; j++) begin
                        s_d[j] <= s_d[j-1];
                    end
                end
            end

            assign sum_out[k*CHUNK +: CHUNK] = s_d[D-1];
        end
    end

    assign bus.out_valid = vld[STAGES-1];
    assign bus.sum       = sum_out;
    assign bus.cout      = carry[STAGES-1];
    // a ^ b ^ sum at the MSB is the carry into the MSB
    assign bus.ovf       = a_msb_q ^ b_msb_q ^ sum_out[WIDTH-1] ^ carry[STAGES-1];

endmodule
